// File: rtl/li_pkg.sv
// Shared RV32I encoding constants and load-immediate FSM states.
// Also holds the LUI/ADDI word builders used by the encoder.
package li_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;
  localparam logic [2:0] F3_ADDI  = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LUI  = 2'd1,
    ST_ADDI = 2'd2
  } li_state_e;

  function automatic logic [31:0] enc_lui(
    input logic [19:0] hi,
    input logic [4:0]  rd
  );
    return {hi, rd, OP_LUI};
  endfunction

  function automatic logic [31:0] enc_addi(
    input logic [11:0] lo,
    input logic [4:0]  rs1,
    input logic [4:0]  rd
  );
    return {lo, rs1, F3_ADDI, rd, OP_OPIMM};
  endfunction

endpackage

// File: rtl/li_split.sv
// Splits a 32-bit constant into LUI/ADDI fields.
// hi is rounded so that the sign-extended lo restores the value.
module li_split (
  input  logic [31:0] i_value,
  output logic [19:0] o_hi,
  output logic [11:0] o_lo
);

  logic [31:0] w_round;

  assign w_round = i_value + 32'h0000_0800;
  assign o_hi    = w_round[31:12];
  assign o_lo    = i_value[11:0];

endmodule

// File: rtl/li_encoder.sv
// Load-immediate encoder: turns a 32-bit constant and rd into
// one or two RV32I words (LUI and/or ADDI) over a valid/ready stream.
module li_encoder
  import li_pkg::*;
#(
  parameter bit ENABLE_SHORT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last
);

  li_state_e   r_state;
  li_state_e   w_next;
  logic [31:0] r_value;
  logic [4:0]  r_rd;
  logic [31:0] r_instr;
  logic        r_last;

  logic [19:0] w_hi;
  logic [11:0] w_lo;
  logic        w_accept;
  logic        w_fire;
  logic        w_hi_zero;
  logic        w_lo_zero;
  logic [31:0] w_first_instr;
  logic        w_first_last;
  li_state_e   w_first_state;

  li_split u_split (
    .i_value (in_value),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state != ST_IDLE);
  assign out_instr = r_instr;
  assign out_last  = r_last;
  assign w_accept  = in_valid & in_ready;
  assign w_fire    = out_valid & out_ready;

  // Mutually exclusive so the priority decoder below stays unique.
  assign w_hi_zero = ENABLE_SHORT & (w_hi == 20'd0);
  assign w_lo_zero = ENABLE_SHORT & ~w_hi_zero & (w_lo == 12'd0);

  always_comb begin
    w_first_instr = enc_lui(w_hi, in_rd);
    w_first_last  = 1'b0;
    w_first_state = ST_LUI;
    unique case (1'b1)
      w_hi_zero: begin
        w_first_instr = enc_addi(w_lo, 5'd0, in_rd);
        w_first_last  = 1'b1;
        w_first_state = ST_ADDI;
      end
      w_lo_zero: begin
        w_first_last  = 1'b1;
      end
      default: begin
        w_first_last  = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = w_first_state;
      end
      ST_LUI: begin
        if (w_fire) w_next = r_last ? ST_IDLE : ST_ADDI;
      end
      ST_ADDI: begin
        if (w_fire) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= 32'd0;
      r_rd    <= 5'd0;
      r_instr <= 32'd0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_value <= in_value;
      r_rd    <= in_rd;
      r_instr <= w_first_instr;
      r_last  <= w_first_last;
    end else if (w_fire && r_state == ST_LUI && !r_last) begin
      // Second word adds the low part onto the LUI result in rd.
      r_instr <= enc_addi(r_value[11:0], r_rd, r_rd);
      r_last  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_li_encoder.sv
// Scoreboard bench for li_encoder: ENABLE_SHORT=1 (dut a) and =0 (dut b).
// Expected words are pushed at issue and popped by per-DUT monitors.
module tb_li_encoder;

  logic        clk;
  logic        rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [31:0] a_in_value, a_out_instr;
  logic [4:0]  a_in_rd;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [31:0] b_in_value, b_out_instr;
  logic [4:0]  b_in_rd;

  logic [32:0] qa[$];
  logic [32:0] qb[$];
  int checks = 0;
  int errors = 0;

  li_encoder #(.ENABLE_SHORT(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_value(a_in_value), .in_rd(a_in_rd),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_instr(a_out_instr), .out_last(a_out_last)
  );

  li_encoder #(.ENABLE_SHORT(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_value(b_in_value), .in_rd(b_in_rd),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_instr(b_out_instr), .out_last(b_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && a_out_valid && a_out_ready) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_word: got %h last=%b, expected nothing",
                 a_out_instr, a_out_last);
      end else begin
        e = qa.pop_front();
        if ({a_out_last, a_out_instr} !== e) begin
          errors++;
          $display("FAIL a_word: got %h last=%b, expected %h last=%b",
                   a_out_instr, a_out_last, e[31:0], e[32]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && b_out_valid && b_out_ready) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_word: got %h last=%b, expected nothing",
                 b_out_instr, b_out_last);
      end else begin
        e = qb.pop_front();
        if ({b_out_last, b_out_instr} !== e) begin
          errors++;
          $display("FAIL b_word: got %h last=%b, expected %h last=%b",
                   b_out_instr, b_out_last, e[31:0], e[32]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Caller sits just after a rising edge.
  task automatic send(input bit sel, input logic [31:0] v,
                      input logic [4:0] rd, input logic [31:0] w0,
                      input logic l0, input logic [31:0] w1);
    int n = 0;
    while (!(sel ? b_in_ready : a_in_ready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk(sel ? "b_accept_ready" : "a_accept_ready",
        {31'd0, (sel ? b_in_ready : a_in_ready)}, 32'd1);
    if (sel) begin
      qb.push_back({l0, w0});
      if (!l0) qb.push_back({1'b1, w1});
      b_in_valid = 1'b1; b_in_value = v; b_in_rd = rd;
    end else begin
      qa.push_back({l0, w0});
      if (!l0) qa.push_back({1'b1, w1});
      a_in_valid = 1'b1; a_in_value = v; a_in_rd = rd;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    chk(sel ? "b_latency" : "a_latency",
        sel ? {30'd0, b_out_valid, b_in_ready}
            : {30'd0, a_out_valid, a_in_ready}, 32'd2);
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", qa.size() + qb.size(), 32'd0);
    chk("idle_after_last",
        {28'd0, a_in_ready, a_out_valid, b_in_ready, b_out_valid},
        32'b1010);
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 0; a_in_value = 0; a_in_rd = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_value = 0; b_in_rd = 0; b_out_ready = 1;
    a_in_value = 32'h12345FFF; a_in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_a", {a_in_ready, a_out_valid, a_out_last, a_out_instr[28:0]},
        32'h8000_0000);
    chk("rst_a_instr", a_out_instr, 32'h0);
    chk("rst_b", {b_in_ready, b_out_valid, b_out_last, b_out_instr[28:0]},
        32'h8000_0000);
    a_in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(0, 32'h12345FFF, 5'd5,  32'h123462B7, 1'b0, 32'hFFF28293);
    drain();
    send(0, 32'h00000123, 5'd1,  32'h12300093, 1'b1, 32'h0);
    send(0, 32'h00000000, 5'd3,  32'h00000193, 1'b1, 32'h0);
    send(0, 32'h00010000, 5'd10, 32'h00010537, 1'b1, 32'h0);
    send(0, 32'hFFFFF800, 5'd2,  32'h80000113, 1'b1, 32'h0);
    send(0, 32'hFFFFFFFF, 5'd0,  32'hFFF00013, 1'b1, 32'h0);
    drain();

    send(1, 32'h00000123, 5'd1,  32'h000000B7, 1'b0, 32'h12308093);
    send(1, 32'h00010000, 5'd10, 32'h00010537, 1'b0, 32'h00050513);
    send(1, 32'h12345FFF, 5'd5,  32'h123462B7, 1'b0, 32'hFFF28293);
    drain();

    a_out_ready = 1'b0;
    send(0, 32'h12345FFF, 5'd5,  32'h123462B7, 1'b0, 32'hFFF28293);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_instr", a_out_instr, 32'h123462B7);
      chk("stall_flags", {29'd0, a_out_valid, a_in_ready, a_out_last},
          32'b100);
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    drain();

    a_out_ready = 1'b0;
    send(0, 32'h12345FFF, 5'd5,  32'h123462B7, 1'b0, 32'hFFF28293);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    @(negedge clk);
    chk("addi_pending", a_out_instr, 32'hFFF28293);
    rst_n = 1'b0;
    #1;
    chk("abort_flags", {30'd0, a_out_valid, a_in_ready}, 32'b01);
    qa.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_resume", {31'd0, a_out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send(0, 32'h00000123, 5'd1, 32'h12300093, 1'b1, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/li_encoder.md
LI_ENCODER -- requirements
Module: li_encoder

Interface
REQ-001 The block SHALL have parameter ENABLE_SHORT, default 1; when 1, it emits single-word sequences where possible, and when 0, it always emits LUI followed by ADDI.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a load-immediate request is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port in_value, input, 32 bits: the constant to materialise.
REQ-007 The block SHALL have port in_rd, input, 5 bits: the destination register index.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_instr holds a valid instruction word.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_instr.
REQ-010 The block SHALL have port out_instr, output, 32 bits: the encoded RV32I instruction word.
REQ-011 The block SHALL have port out_last, output, 1 bit: out_instr is the final word of the current sequence.

Function
REQ-012 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_value and in_rd are captured into internal registers.
REQ-013 in_ready SHALL be 1 only in state IDLE; no request is accepted while a sequence is in flight.
REQ-014 The split SHALL be: hi[19:0] = (in_value + 32'h800)[31:12], computed modulo 2^32; lo[11:0] = in_value[11:0].
REQ-015 The LUI word SHALL be {hi, rd, 7'b0110111}.
REQ-016 The ADDI word SHALL be {lo, rs1, 3'b000, rd, 7'b0010011}, where rs1 = rd after a LUI and rs1 = 5'd0 otherwise.
REQ-017 The FSM SHALL have states IDLE, EMIT_LUI and EMIT_ADDI.
REQ-018 On accept with ENABLE_SHORT=1:
  - hi==0 -> EMIT_ADDI with rs1=x0 and out_last=1.
  - else lo==0 -> EMIT_LUI with out_last=1.
  - else -> EMIT_LUI with out_last=0.
REQ-019 On accept with ENABLE_SHORT=0, the FSM SHALL always go to EMIT_LUI with out_last=0.
REQ-020 out_valid SHALL be 1 exactly in EMIT_LUI and EMIT_ADDI, and out_instr/out_last SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-021 On an out_valid and out_ready handshake: in EMIT_LUI, go to EMIT_ADDI if out_last=0, else to IDLE; in EMIT_ADDI, go to IDLE.
REQ-022 The first output word SHALL be valid on the cycle after accept (1-cycle latency); back-to-back handshakes SHALL give one word per cycle.
REQ-023 in_ready SHALL rise on the cycle after the last word's handshake; there is no same-cycle accept-while-finishing.
REQ-024 rd = 0 SHALL be encoded normally, with no special-casing.

Reset
REQ-025 While rst_n=0, state SHALL be IDLE, in_ready=1, out_valid=0, out_last=0, out_instr=32'h0, and the captured registers SHALL be 0.
REQ-026 Reset asserted mid-sequence SHALL abort the sequence immediately; no further words of that sequence are emitted after release.

Structure
REQ-027 The opcode constants (OP_LUI=7'b0110111, OP_OPIMM=7'b0010011), F3_ADDI=3'b000 and the FSM state encoding SHALL live in the shared RV32I package.
REQ-028 A combinational sub-module li_split SHALL compute hi and lo from the 32-bit value and is reusable by other blocks.

Verification
REQ-029 in_value=32'h12345FFF, rd=5 -> 32'h123462B7 (out_last=0), then 32'hFFF28293 (out_last=1).
REQ-030 in_value=32'h00000123, rd=1 -> a single word 32'h12300093 with out_last=1; in_value=32'h00000000, rd=3 -> 32'h00000193.
REQ-031 in_value=32'h00010000, rd=10 -> a single word 32'h00010537 with out_last=1; in_value=32'hFFFFF800, rd=2 -> a single word 32'h80000113 (hi wraps to 0).
REQ-032 ENABLE_SHORT=0, in_value=32'h00000123, rd=1 -> 32'h000000B7, then 32'h12308093.
REQ-033 Case 029 with out_ready held 0 for 5 cycles -> out_instr is stable, in_ready=0 throughout, and there are no duplicate or lost words.
REQ-034 rst_n pulsed low while in EMIT_ADDI -> out_valid=0 immediately, in_ready=1, and a new request afterwards encodes correctly.
